// File: rtl/pwmencoder_wb.sv
// pwmencoder_wb
//   Wishbone slave that generates four RC servo/ESC PWM outputs. Each pulse
//   width is given in microseconds, and every output shares one fixed frame
//   period. The host writes widths into shadow registers. The shadow values
//   are copied to the active registers only at a frame start, so a pulse is
//   never cut short or stretched part-way through a frame.
//
//   Register map (word index = wb_adr_i[4:2]):
//     0-3  WIDTH_n  [15:0] pulse width in us, clamped on write (RW)
//     4    CTRL     [0] enable (RW)
//     5    STATUS   [31:16] frame_count, [0] enable (RO, writes acked and ignored)
//     6-7  unmapped -> wb_err_o
//
// Ports
//   i_clk, i_rstn      clock, asynchronous active-low reset
//   wb_adr_i           byte address
//   wb_dat_i           write data
//   wb_dat_o           read data, valid while wb_ack_o is high
//   wb_we_i            write enable
//   wb_sel_i           byte lane enables
//   wb_stb_i           strobe
//   wb_cyc_i           cycle
//   wb_ack_o           one-cycle acknowledge
//   wb_err_o           one-cycle error (unmapped address)
//   wb_rty_o           retry, always 0
//   o_pwm_0..o_pwm_3   active-high PWM outputs
//   o_frame_stb        one-cycle pulse at each frame wrap
module pwmencoder_wb #(
    parameter int CLK_FREQ_HZ = 48_000_000,
    parameter int FRAME_US    = 2500,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        o_pwm_0,
    output logic        o_pwm_1,
    output logic        o_pwm_2,
    output logic        o_pwm_3,
    output logic        o_frame_stb
);

    localparam int CLK_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int UW      = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [UW-1:0] US_LAST  = UW'(FRAME_US - 1);
    localparam logic [15:0]   MIN_W    = 16'(MIN_US);
    localparam logic [15:0]   MAX_W    = 16'(MAX_US);

    logic [15:0]   shadow [4];
    logic [15:0]   active [4];
    logic          enable;
    logic [15:0]   frame_count;
    logic [PW-1:0] prescaler;
    logic [UW-1:0] us_cnt;
    logic [3:0]    pwm_q;
    logic          frame_stb_q;

    logic [2:0]    idx;
    logic          request;
    logic          us_tick;
    logic          frame_wrap;
    logic [15:0]   merged_width;
    logic [31:0]   read_data;

    // Zero is kept as-is so that a channel can be disarmed. Every other
    // value is forced into the legal servo range.
    function automatic logic [15:0] clamp_width(input logic [15:0] w);
        if (w == 16'd0)
            return 16'd0;
        else if (w < MIN_W)
            return MIN_W;
        else if (w > MAX_W)
            return MAX_W;
        else
            return w;
    endfunction

    assign idx        = wb_adr_i[4:2];
    assign request    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign us_tick    = (prescaler == PRE_LAST);
    assign frame_wrap = enable & us_tick & (us_cnt == US_LAST);

    assign wb_rty_o    = 1'b0;
    assign o_pwm_0     = pwm_q[0];
    assign o_pwm_1     = pwm_q[1];
    assign o_pwm_2     = pwm_q[2];
    assign o_pwm_3     = pwm_q[3];
    assign o_frame_stb = frame_stb_q;

    // Address bits outside the word index, the upper data half and the upper
    // byte lanes have no destination in this register map.
    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    // Byte-lane merge of a WIDTH write with the shadow value it replaces.
    // Clamping is applied to the merged result, not to the raw bus data.
    always_comb begin
        merged_width = shadow[idx[1:0]];
        if (wb_sel_i[0])
            merged_width[7:0] = wb_dat_i[7:0];
        if (wb_sel_i[1])
            merged_width[15:8] = wb_dat_i[15:8];
    end

    // Read multiplexer. Indices 6 and 7 return 0, but they answer with err.
    always_comb begin
        read_data = '0;
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: read_data = {16'h0000, shadow[idx[1:0]]};
            3'd4:                   read_data = {31'd0, enable};
            3'd5:                   read_data = {frame_count, 15'd0, enable};
            default:                read_data = '0;
        endcase
    end

    // Bus slave. The response is registered, so ack/err blocks the request
    // term for one cycle. This forces a one-cycle gap between back-to-back
    // accesses.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            enable   <= 1'b0;
            for (int i = 0; i < 4; i++)
                shadow[i] <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            if (request) begin
                if (idx > 3'd5) begin
                    wb_err_o <= 1'b1;
                    wb_dat_o <= '0;
                end else begin
                    wb_ack_o <= 1'b1;
                    wb_dat_o <= read_data;
                    if (wb_we_i) begin
                        if (idx < 3'd4)
                            shadow[idx[1:0]] <= clamp_width(merged_width);
                        else if (idx == 3'd4 && wb_sel_i[0])
                            enable <= wb_dat_i[0];
                    end
                end
            end
        end
    end

    // Timebase and outputs. While disabled, the counters are parked at zero
    // and the active widths follow the shadows. Enabling the block therefore
    // starts a fresh frame at once, using the latest widths. While enabled,
    // the active widths are reloaded only on the frame wrap. The
    // non-blocking read picks up the pre-write shadow if a bus write lands
    // on that same edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            prescaler   <= '0;
            us_cnt      <= '0;
            frame_count <= '0;
            frame_stb_q <= 1'b0;
            pwm_q       <= '0;
            for (int i = 0; i < 4; i++)
                active[i] <= '0;
        end else if (!enable) begin
            prescaler   <= '0;
            us_cnt      <= '0;
            frame_stb_q <= 1'b0;
            pwm_q       <= '0;
            for (int i = 0; i < 4; i++)
                active[i] <= shadow[i];
        end else begin
            frame_stb_q <= frame_wrap;
            if (us_tick) begin
                prescaler <= '0;
                us_cnt    <= (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (frame_wrap) begin
                frame_count <= frame_count + 16'd1;
                for (int i = 0; i < 4; i++)
                    active[i] <= shadow[i];
            end
            for (int i = 0; i < 4; i++)
                pwm_q[i] <= (16'(us_cnt) < active[i]);
        end
    end

endmodule
